// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-layer controller and its neuron datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package snn_pkg;

  localparam int SNN_SIZE        = 8;
  localparam int SNN_NUM_INPUTS  = 16;
  localparam int SNN_NUM_OUTPUTS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DECAY = 3'd3,
    ST_DONE  = 3'd4
  } snn_state_t;

  // Index/address width for n entries, never narrower than one bit
  function automatic int snn_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_layer_ctrl_neuron.sv
// Neuron datapath: accumulate (v+w, wraps) or decay/fire (v*beta truncated, fire if > v_th, reset to 0 on fire).
// Latency: purely combinational; the caller registers v_mem_out.
// Backpressure: none; evaluated every cycle.
module neuron #(
  parameter int SIZE = 8
) (
  input  logic            function_sel,
  input  logic [SIZE-1:0] v_mem_in,
  input  logic [SIZE-1:0] weight,
  input  logic [SIZE-1:0] beta,
  input  logic [SIZE-1:0] v_th,
  output logic [SIZE-1:0] v_mem_out,
  output logic            spike
);

  logic [SIZE-1:0] w_sum;
  logic [SIZE-1:0] w_decayed;
  logic            w_fire;

  // Both results are computed in SIZE-bit context so carries and high product bits drop naturally
  assign w_sum     = v_mem_in + weight;
  assign w_decayed = v_mem_in * beta;
  assign w_fire    = (w_decayed > v_th);

  assign v_mem_out = function_sel ? (w_fire ? '0 : w_decayed) : w_sum;
  assign spike     = function_sel & w_fire;

endmodule

// File: rtl/snn_layer_ctrl.sv
// Time-step controller for one fully connected spiking layer; owns the membrane register file and one shared neuron.
// Latency: out_valid 2 + NUM_OUTPUTS + sum_i(spk[i] ? NUM_OUTPUTS : 1) cycles after start is accepted.
// Backpressure: none; one weight read per cycle, start ignored while busy. Optional SNN_SPIKE_COUNT_EN adds fire counters.
module snn_layer_ctrl
  import snn_pkg::*;
#(
  parameter int SIZE        = SNN_SIZE,
  parameter int NUM_INPUTS  = SNN_NUM_INPUTS,
  parameter int NUM_OUTPUTS = SNN_NUM_OUTPUTS,
  parameter int ADDR_W      = snn_clog2_min1(NUM_INPUTS * NUM_OUTPUTS)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start,
  input  logic [NUM_INPUTS-1:0]    spike_in,
  input  logic [SIZE-1:0]          beta,
  input  logic [SIZE-1:0]          v_th,
  input  logic                     vmem_clear,
`ifdef SNN_SPIKE_COUNT_EN
  input  logic                     count_clear,
  output logic [NUM_OUTPUTS*8-1:0] spike_count,
`endif
  output logic                     weight_rd_en,
  output logic [ADDR_W-1:0]        weight_addr,
  input  logic [SIZE-1:0]          weight_data,
  output logic                     busy,
  output logic [NUM_OUTPUTS-1:0]   spike_out,
  output logic                     out_valid
);

  localparam int IW = snn_clog2_min1(NUM_INPUTS);
  localparam int JW = snn_clog2_min1(NUM_OUTPUTS);

  snn_state_t             r_state;
  logic [NUM_INPUTS-1:0]  r_spk_q;
  logic [IW-1:0]          r_i;
  logic [JW-1:0]          r_j;
  logic [JW-1:0]          r_j_d;
  logic                   r_apply_vld;
  logic [SIZE-1:0]        r_vmem [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] r_spk_acc;
  logic [NUM_OUTPUTS-1:0] r_spike_out;
  logic                   r_out_valid;
  logic                   r_busy;

  logic                   w_decay;
  logic [SIZE-1:0]        w_nrn_vin;
  logic [SIZE-1:0]        w_nrn_vout;
  logic                   w_nrn_spike;
  logic                   w_last_i;
  logic                   w_last_j;
  logic                   w_row_end;
  logic [NUM_OUTPUTS-1:0] w_spk_next;

  // The single neuron serves the apply stage (accumulate) and the decay pass; they never overlap thanks to DRAIN
  assign w_decay   = (r_state == ST_DECAY);
  assign w_nrn_vin = w_decay ? r_vmem[r_j] : r_vmem[r_j_d];

  neuron #(.SIZE(SIZE)) u_neuron (
    .function_sel (w_decay),
    .v_mem_in     (w_nrn_vin),
    .weight       (weight_data),
    .beta         (beta),
    .v_th         (v_th),
    .v_mem_out    (w_nrn_vout),
    .spike        (w_nrn_spike)
  );

  assign w_last_i  = (r_i == IW'(NUM_INPUTS - 1));
  assign w_last_j  = (r_j == JW'(NUM_OUTPUTS - 1));
  // A silent input lane costs one cycle; an active lane costs one cycle per output neuron
  assign w_row_end = !r_spk_q[r_i] || w_last_j;

  // Read strobe/address decode straight from registered state so read data lands exactly in the apply cycle
  assign weight_rd_en = (r_state == ST_ACCUM) && r_spk_q[r_i];
  assign weight_addr  = (r_state == ST_ACCUM)
                        ? (ADDR_W'(r_i) * ADDR_W'(NUM_OUTPUTS) + ADDR_W'(r_j))
                        : '0;

  // Spike vector including the neuron decided in the current cycle, published on entry to DONE
  always_comb begin
    w_spk_next      = r_spk_acc;
    w_spk_next[r_j] = w_nrn_spike;
  end

  assign busy      = r_busy;
  assign spike_out = r_spike_out;
  assign out_valid = r_out_valid;

  // Step FSM, membrane register file and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_spk_q     <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_j_d       <= '0;
      r_apply_vld <= 1'b0;
      r_spk_acc   <= '0;
      r_spike_out <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int k = 0; k < NUM_OUTPUTS; k++) r_vmem[k] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_apply_vld <= 1'b0;
      // Apply stage: weight_data answers the read issued last cycle
      if (r_apply_vld) r_vmem[r_j_d] <= w_nrn_vout;

      case (r_state)
        ST_IDLE: begin
          // Clear lands at the accept edge, so a simultaneous start accumulates from zero
          if (vmem_clear) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) r_vmem[k] <= '0;
          end
          if (start) begin
            r_spk_q <= spike_in;
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (r_spk_q[r_i]) begin
            r_apply_vld <= 1'b1;
            r_j_d       <= r_j;
            r_j         <= w_last_j ? '0 : r_j + JW'(1);
          end
          if (w_row_end) begin
            if (w_last_i) r_state <= ST_DRAIN;
            else          r_i     <= r_i + IW'(1);
          end
        end
        ST_DRAIN: begin
          r_j     <= '0;
          r_state <= ST_DECAY;
        end
        ST_DECAY: begin
          r_vmem[r_j]    <= w_nrn_vout;
          r_spk_acc[r_j] <= w_nrn_spike;
          if (w_last_j) begin
            r_spike_out <= w_spk_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_j <= r_j + JW'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_i     <= '0;
          r_j     <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SNN_SPIKE_COUNT_EN
  logic [7:0] r_cnt [NUM_OUTPUTS];

  // Per-neuron fire counters, saturating at 255, clearable only while idle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) r_cnt[k] <= '0;
    end else if ((r_state == ST_IDLE) && count_clear) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) r_cnt[k] <= '0;
    end else if (w_decay && w_nrn_spike && (r_cnt[r_j] != 8'hFF)) begin
      r_cnt[r_j] <= r_cnt[r_j] + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt
    assign spike_count[g*8 +: 8] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_snn_layer_ctrl.sv
// Scoreboard bench for snn_layer_ctrl at SIZE=8, NUM_INPUTS=4, NUM_OUTPUTS=2 with a 1-cycle weight memory.
// Latency: expected out_valid cycle is carried in each scoreboard entry.
// Backpressure: none; the monitor pops one entry per out_valid pulse.
module tb_snn_layer_ctrl;

  localparam int SIZE = 8;
  localparam int NI   = 4;
  localparam int NO   = 2;
  localparam int AW   = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NI-1:0]  spike_in;
  logic [SIZE-1:0] beta;
  logic [SIZE-1:0] v_th;
  logic           vmem_clear;
  logic           weight_rd_en;
  logic [AW-1:0]  weight_addr;
  logic [SIZE-1:0] weight_data;
  logic           busy;
  logic [NO-1:0]  spike_out;
  logic           out_valid;
`ifdef SNN_SPIKE_COUNT_EN
  logic           count_clear;
  logic [NO*8-1:0] spike_count;
`endif

  always #5 clk = ~clk;

  snn_layer_ctrl #(.SIZE(SIZE), .NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .start        (start),
    .spike_in     (spike_in),
    .beta         (beta),
    .v_th         (v_th),
    .vmem_clear   (vmem_clear),
`ifdef SNN_SPIKE_COUNT_EN
    .count_clear  (count_clear),
    .spike_count  (spike_count),
`endif
    .weight_rd_en (weight_rd_en),
    .weight_addr  (weight_addr),
    .weight_data  (weight_data),
    .busy         (busy),
    .spike_out    (spike_out),
    .out_valid    (out_valid)
  );

  typedef struct {
    logic [NO-1:0] spk;
    logic [7:0]    v0;
    logic [7:0]    v1;
    int            lat;
    logic [7:0]    mask;
    int            s_cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] rd_mask  = '0;
  logic [7:0] wmem [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Weight memory: data valid one cycle after the strobe
  always @(posedge clk) begin
    if (weight_rd_en) weight_data <= wmem[weight_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect read addresses, score every out_valid pulse against the queue
  always @(negedge clk) begin
    exp_t e;
    if (weight_rd_en) rd_mask = rd_mask | (8'd1 << weight_addr);
    if (rst) rd_mask = '0;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("spike_out",  {30'd0, spike_out}, {30'd0, e.spk});
        check("v_mem0",     {24'd0, dut.r_vmem[0]}, {24'd0, e.v0});
        check("v_mem1",     {24'd0, dut.r_vmem[1]}, {24'd0, e.v1});
        check("latency",    cyc - e.s_cyc, e.lat);
        check("read_addrs", {24'd0, rd_mask}, {24'd0, e.mask});
        check("busy_in_done", {31'd0, busy}, 32'd1);
      end
      rd_mask = '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NO-1:0] e_spk, input logic [7:0] e0, input logic [7:0] e1,
                          input int e_lat, input logic [7:0] e_mask);
    exp_t e;
    e.spk = e_spk; e.v0 = e0; e.v1 = e1; e.lat = e_lat; e.mask = e_mask; e.s_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      tick(1);
      guard++;
    end
    if (guard >= 100) check("step_timeout", {31'd0, busy}, 32'd0);
  endtask

  // One time step: called while idle, #1 after a rising edge
  task automatic run_step(input logic [NI-1:0] spk, input logic clr, input logic [NO-1:0] e_spk,
                          input logic [7:0] e0, input logic [7:0] e1, input int e_lat,
                          input logic [7:0] e_mask);
    spike_in = spk; vmem_clear = clr; start = 1'b1;
    push_exp(e_spk, e0, e1, e_lat, e_mask);
    tick(1);
    start = 1'b0; vmem_clear = 1'b0; spike_in = '0;
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vmem_clear = 1'b0; spike_in = '0; beta = '0; v_th = '0;
`ifdef SNN_SPIKE_COUNT_EN
    count_clear = 1'b0;
`endif
    for (int k = 0; k < 8; k++) wmem[k] = 8'd7;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rd_en",     {31'd0, weight_rd_en}, 32'd0);
    check("rst_addr",      {29'd0, weight_addr}, 32'd0);
    check("rst_spike_out", {30'd0, spike_out}, 32'd0);
    check("rst_vmem0",     {24'd0, dut.r_vmem[0]}, 32'd0);

    // Basic fire, strict threshold across steps, clear-with-start
    wmem[0] = 8'd5; wmem[1] = 8'd20; beta = 8'd1; v_th = 8'd10;
    run_step(4'b0001, 1'b0, 2'b10, 8'd5,  8'd0, 9, 8'h03);
    run_step(4'b0001, 1'b0, 2'b10, 8'd10, 8'd0, 9, 8'h03);
    run_step(4'b0001, 1'b1, 2'b10, 8'd5,  8'd0, 9, 8'h03);
    run_step(4'b0001, 1'b0, 2'b10, 8'd10, 8'd0, 9, 8'h03);
    run_step(4'b0001, 1'b0, 2'b11, 8'd0,  8'd0, 9, 8'h03);

    // Add wrap (200, 400->144), then truncated decay ((144+200)%256=88, 88*2=176)
    wmem[0] = 8'd200; wmem[1] = 8'd0; beta = 8'd1; v_th = 8'd255;
    run_step(4'b0001, 1'b0, 2'b00, 8'd200, 8'd0, 9, 8'h03);
    run_step(4'b0001, 1'b0, 2'b00, 8'd144, 8'd0, 9, 8'h03);
    beta = 8'd2;
    run_step(4'b0001, 1'b0, 2'b00, 8'd176, 8'd0, 9, 8'h03);

    // All-zero input: no reads, decay 176*2=352->96 > 50 fires
    v_th = 8'd50;
    run_step(4'b0000, 1'b0, 2'b01, 8'd0, 8'd0, 8, 8'h00);

    // Start (with clear) while busy is ignored: v0=1+3=4, v1=2+4=6 fires at v_th=5
    wmem[0] = 8'd1; wmem[1] = 8'd2; wmem[2] = 8'd3; wmem[3] = 8'd4; beta = 8'd1; v_th = 8'd5;
    spike_in = 4'b0011; start = 1'b1;
    push_exp(2'b10, 8'd4, 8'd0, 10, 8'h0F);
    tick(1);
    start = 1'b0; spike_in = '0;
    tick(2);
    start = 1'b1; vmem_clear = 1'b1; spike_in = 4'b1111;
    tick(1);
    start = 1'b0; vmem_clear = 1'b0; spike_in = '0;
    wait_idle();
    tick(5);

    // Reset during ACCUM aborts the step
    spike_in = 4'b1111; start = 1'b1;
    tick(1);
    start = 1'b0; spike_in = '0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_busy",      {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_rd_en",     {31'd0, weight_rd_en}, 32'd0);
    check("abort_addr",      {29'd0, weight_addr}, 32'd0);
    check("abort_spike_out", {30'd0, spike_out}, 32'd0);
    check("abort_vmem0",     {24'd0, dut.r_vmem[0]}, 32'd0);
    tick(30);

    // Fresh step after reset starts from zero potentials
    v_th = 8'd255;
    run_step(4'b0001, 1'b0, 2'b00, 8'd1, 8'd2, 9, 8'h03);

`ifdef SNN_SPIKE_COUNT_EN
    // Neuron 1 fires every step; its counter saturates, then clears
    wmem[0] = 8'd0; wmem[1] = 8'd1; beta = 8'd1; v_th = 8'd0;
    for (int k = 0; k < 300; k++) begin
      run_step(4'b0001, (k == 0), 2'b10, 8'd0, 8'd0, 9, 8'h03);
    end
    check("count1_saturated", {24'd0, spike_count[15:8]}, 32'd255);
    check("count0_idle",      {24'd0, spike_count[7:0]}, 32'd0);
    count_clear = 1'b1;
    tick(1);
    count_clear = 1'b0;
    check("count1_cleared",   {24'd0, spike_count[15:8]}, 32'd0);
`endif

    tick(3);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
